// File: rtl/rhythm_audio_pkg.sv
// Shared types and constants for the audio capture path.
// Used by i2s_rx_deserializer and i2s_capture.
package rhythm_audio_pkg;

    typedef logic [15:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } cap_state_t;

    localparam int FRAMES_PER_WORD       = 4;
    localparam int MONO_SAMPLES_PER_WORD = 8;
    localparam int SDRAM_WORD_W          = 128;

endpackage

// File: rtl/i2s_rx_deserializer.sv
// I2S slave receiver: synchronises SClk/LRClk/Din, frames slots
// with the one-bit delay and emits complete {L,R} frames.
module i2s_rx_deserializer
    import rhythm_audio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          SClk,
    input  logic          LRClk,
    input  logic          Din,
    output logic          frame_valid,
    output stereo_frame_t frame,
    output logic          lr_fall
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   sclk_prev_q;

    logic          lr_prev_q;
    logic [4:0]    bitcnt_q;
    logic [15:0]   shift_q;
    sample_t       left_q;
    logic          left_vld_q;
    stereo_frame_t frame_q;
    logic          frame_valid_q;
    logic          lr_fall_q;

    logic          sclk_s;
    logic          lr_s;
    logic          din_s;
    logic          rise;
    logic          lr_change;
    logic          shift_en;
    logic          sample_done;
    logic [15:0]   sample_c;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s        = lr_sync_q[SYNC_STAGES-1];
    assign din_s       = din_sync_q[SYNC_STAGES-1];
    assign rise        = sclk_s & ~sclk_prev_q;
    assign lr_change   = lr_s != lr_prev_q;
    assign shift_en    = rise & ~lr_change & (bitcnt_q != 5'd16);
    assign sample_done = shift_en & (bitcnt_q == 5'd15);
    assign sample_c    = {shift_q[14:0], din_s};

    // Bring the codec's asynchronous lines into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SClk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], LRClk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], Din};
            sclk_prev_q <= sclk_s;
        end
    end

    // Slot framing, MSB-first shift and stereo frame assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev_q     <= 1'b0;
            bitcnt_q      <= 5'd16;
            shift_q       <= '0;
            left_q        <= '0;
            left_vld_q    <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            lr_fall_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            lr_fall_q     <= 1'b0;
            if (rise) begin
                lr_prev_q <= lr_s;
            end
            if (rise && lr_change) begin
                bitcnt_q  <= 5'd0;
                lr_fall_q <= ~lr_s;
            end else if (shift_en) begin
                bitcnt_q <= bitcnt_q + 5'd1;
                shift_q  <= sample_c;
            end
            if (sample_done) begin
                if (!lr_s) begin
                    left_q     <= sample_c;
                    left_vld_q <= 1'b1;
                end else if (left_vld_q) begin
                    frame_q       <= '{l: left_q, r: sample_c};
                    frame_valid_q <= 1'b1;
                    left_vld_q    <= 1'b0;
                end
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame       = frame_q;
    assign lr_fall     = lr_fall_q;

endmodule

// File: rtl/i2s_capture.sv
// I2S capture: packs received frames into 128-bit words for an SDRAM ring.
// Define I2S_CAPTURE_MONO_EN to store only the left channel.
module i2s_capture
    import rhythm_audio_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR   = 22'h200000,
    parameter logic [21:0] LEN_WORDS   = 22'h010000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    SClk,
    input  logic                    LRClk,
    input  logic                    Din,
    input  logic                    sdram_wait,
    input  logic                    sdram_ac,
    output logic                    sdram_wr,
    output logic [21:0]             sdram_addr,
    output logic [SDRAM_WORD_W-1:0] sdram_wrdata,
    output logic                    busy,
    output logic                    overrun,
    output logic                    wrap_pulse
);

`ifdef I2S_CAPTURE_MONO_EN
    localparam int SLOTS  = MONO_SAMPLES_PER_WORD;
    localparam int SLOT_W = 16;
`else
    localparam int SLOTS  = FRAMES_PER_WORD;
    localparam int SLOT_W = 32;
`endif
    localparam int CNT_W = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
    localparam logic [21:0] LAST_ADDR = BASE_ADDR + LEN_WORDS - 22'd1;

    logic          frame_valid;
    logic          lr_fall;
    stereo_frame_t frame;
    logic [SLOT_W-1:0] slot_data;

    cap_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [SDRAM_WORD_W-1:0] word_q;
    logic [SDRAM_WORD_W-1:0] word_d;

    logic                    sdram_wr_q;
    logic [21:0]             addr_q;
    logic [SDRAM_WORD_W-1:0] data_q;
    logic                    overrun_q;
    logic                    wrap_q;

    logic take;
    logic word_done;
    logic go_sync;
    logic ack;

    i2s_rx_deserializer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .SClk       (SClk),
        .LRClk      (LRClk),
        .Din        (Din),
        .frame_valid(frame_valid),
        .frame      (frame),
        .lr_fall    (lr_fall)
    );

`ifdef I2S_CAPTURE_MONO_EN
    assign slot_data = frame.l;
`else
    assign slot_data = frame;
`endif

    assign take      = frame_valid & enable & (state_q == RUN);
    assign word_done = take & (cnt_q == LAST_SLOT);
    assign go_sync   = (state_q == IDLE) & enable;
    assign ack       = sdram_ac & sdram_wr_q & ~sdram_wait;

    // Current word with the incoming frame dropped into its slot.
    always_comb begin
        word_d = word_q;
        word_d[cnt_q*SLOT_W +: SLOT_W] = slot_data;
    end

    // Capture FSM and packer; any state other than RUN restarts the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (enable) state_q <= SYNC;
                SYNC: begin
                    if (!enable)      state_q <= IDLE;
                    else if (lr_fall) state_q <= RUN;
                end
                RUN:  if (!enable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (state_q != RUN) begin
                cnt_q <= '0;
            end else if (take) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                word_q <= word_d;
            end
        end
    end

    // Single pending write; an ack frees the slot for a word completing now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdram_wr_q <= 1'b0;
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
            overrun_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (go_sync) begin
                overrun_q <= 1'b0;
            end
            if (ack) begin
                addr_q     <= (addr_q == LAST_ADDR) ? BASE_ADDR
                                                    : addr_q + 22'd1;
                wrap_q     <= addr_q == LAST_ADDR;
                sdram_wr_q <= word_done;
                if (word_done) begin
                    data_q <= word_d;
                end
            end else if (word_done) begin
                if (sdram_wr_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    sdram_wr_q <= 1'b1;
                    data_q     <= word_d;
                end
            end
        end
    end

    assign sdram_wr     = sdram_wr_q;
    assign sdram_addr   = addr_q;
    assign sdram_wrdata = data_q;
    assign overrun      = overrun_q;
    assign wrap_pulse   = wrap_q;
    assign busy         = (state_q != IDLE) | sdram_wr_q;

endmodule
